// File: rtl/dense_layer_if.sv
// Port bundle of the fully-connected stage: sequencer control plus pixel/weight memory ports.
// master = sequencer and memories, slave = dense_layer.
interface dense_layer_if #(
    parameter int SIZE_1           = 11,
    parameter int SIZE_W           = 9,
    parameter int SIZE_address_pix = 13,
    parameter int SIZE_address_wei = 14
);
    logic                          dense_en;
    logic                          STOP;
    logic [SIZE_address_pix-1:0]   memstartp;
    logic [SIZE_address_pix-1:0]   memstartzap;
    logic [SIZE_address_wei-1:0]   memstartw;
    logic [9:0]                    in_len;
    logic [6:0]                    out_len;
    logic [SIZE_address_pix-1:0]   read_addressp;
    logic                          re;
    logic signed [SIZE_1-1:0]      qp;
    logic [SIZE_address_wei-1:0]   read_addressw;
    logic                          re_w;
    logic signed [SIZE_W-1:0]      qw;
    logic [SIZE_address_pix-1:0]   write_addressp;
    logic                          we;
    logic signed [SIZE_1-1:0]      dp;

    modport master (
        output dense_en, memstartp, memstartzap, memstartw, in_len, out_len, qp, qw,
        input  STOP, read_addressp, re, read_addressw, re_w, write_addressp, we, dp
    );

    modport slave (
        input  dense_en, memstartp, memstartzap, memstartw, in_len, out_len, qp, qw,
        output STOP, read_addressp, re, read_addressw, re_w, write_addressp, we, dp
    );
endinterface

// File: rtl/dense_layer.sv
// Fully-connected layer: one signed MAC dot product per output neuron, scaled and saturated.
// Optional macro DENSE_RELU_EN clamps negative results to zero before they are written.
module dense_layer #(
    parameter int SIZE_1           = 11,
    parameter int SIZE_W           = 9,
    parameter int SIZE_address_pix = 13,
    parameter int SIZE_address_wei = 14,
    parameter int ACC_W            = 32,
    parameter int FRAC             = 8
) (
    input logic          clk,
    input logic          rst,
    dense_layer_if.slave bus
);

    localparam int PROD_W = SIZE_1 + SIZE_W;
    localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'((1 << (SIZE_1 - 1)) - 1);
    localparam logic signed [ACC_W-1:0] SAT_MIN = ~SAT_MAX;

    typedef enum logic [2:0] {IDLE, ISSUE, DRAIN, WRITE, DONE} state_t;

    state_t                      state, state_nxt;
    logic [9:0]                  k;
    logic [6:0]                  o;
    logic [6:0]                  o_inc;
    logic [9:0]                  last_k;
    logic                        drain_cnt;
    logic [SIZE_address_wei-1:0] woff;

    logic                        vld_p1, vld_p2;
    logic signed [PROD_W-1:0]    qp_ext, qw_ext, prod_p2;
    logic signed [ACC_W-1:0]     prod_ext, acc, acc_sum;

    function automatic logic signed [SIZE_1-1:0] scale_sat(input logic signed [ACC_W-1:0] a);
        logic signed [ACC_W-1:0] r;
        r = a >>> FRAC;
        if (r > SAT_MAX)
            return SAT_MAX[SIZE_1-1:0];
        else if (r < SAT_MIN)
            return SAT_MIN[SIZE_1-1:0];
        else
            return r[SIZE_1-1:0];
    endfunction

    function automatic logic signed [SIZE_1-1:0] relu(input logic signed [SIZE_1-1:0] v);
`ifdef DENSE_RELU_EN
        return v[SIZE_1-1] ? '0 : v;
`else
        return v;
`endif
    endfunction

    assign o_inc  = o + 7'd1;
    assign last_k = bus.in_len - 10'd1;

    always_comb begin
        state_nxt = state;
        if (!bus.dense_en) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE:    if (!bus.STOP) state_nxt = ISSUE;
                ISSUE:   if (k == last_k) state_nxt = DRAIN;
                DRAIN:   if (drain_cnt) state_nxt = WRITE;
                WRITE:   state_nxt = (o_inc == bus.out_len) ? DONE : ISSUE;
                DONE:    state_nxt = DONE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    // Control: state and loop counters. woff is the running weight row offset o*N.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            k         <= '0;
            o         <= '0;
            drain_cnt <= 1'b0;
            woff      <= '0;
        end else begin
            state <= state_nxt;
            if (!bus.dense_en || state == IDLE) begin
                k         <= '0;
                o         <= '0;
                drain_cnt <= 1'b0;
                woff      <= '0;
            end else begin
                case (state)
                    ISSUE: k <= k + 10'd1;
                    DRAIN: drain_cnt <= ~drain_cnt;
                    WRITE: begin
                        k    <= '0;
                        o    <= o_inc;
                        woff <= woff + SIZE_address_wei'(bus.in_len);
                    end
                    default: ;
                endcase
            end
        end
    end

    // Stage 0: registered read/write ports, one cycle behind the state that produced them.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.re             <= 1'b0;
            bus.re_w           <= 1'b0;
            bus.we             <= 1'b0;
            bus.STOP           <= 1'b0;
            bus.read_addressp  <= '0;
            bus.read_addressw  <= '0;
            bus.write_addressp <= '0;
            bus.dp             <= '0;
        end else if (!bus.dense_en) begin
            bus.re             <= 1'b0;
            bus.re_w           <= 1'b0;
            bus.we             <= 1'b0;
            bus.STOP           <= 1'b0;
            bus.read_addressp  <= '0;
            bus.read_addressw  <= '0;
            bus.write_addressp <= '0;
            bus.dp             <= '0;
        end else begin
            bus.re   <= (state == ISSUE);
            bus.re_w <= (state == ISSUE);
            bus.we   <= (state == WRITE);
            bus.STOP <= (state == DONE);
            if (state == ISSUE) begin
                bus.read_addressp <= bus.memstartp + SIZE_address_pix'(k);
                bus.read_addressw <= bus.memstartw + woff + SIZE_address_wei'(k);
            end
            // acc_sum already holds the final product, which lands in this same cycle
            if (state == WRITE) begin
                bus.write_addressp <= bus.memstartzap + SIZE_address_pix'(o);
                bus.dp             <= relu(scale_sat(acc_sum));
            end
        end
    end

    // Stage 1 -> 2: read data returns two cycles after re, tracked by the valid pipe.
    assign qp_ext   = {{SIZE_W{bus.qp[SIZE_1-1]}}, bus.qp};
    assign qw_ext   = {{SIZE_1{bus.qw[SIZE_W-1]}}, bus.qw};
    assign prod_p2  = qp_ext * qw_ext;
    assign prod_ext = {{(ACC_W - PROD_W){prod_p2[PROD_W-1]}}, prod_p2};
    assign acc_sum  = vld_p2 ? acc + prod_ext : acc;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_p1 <= 1'b0;
            vld_p2 <= 1'b0;
            acc    <= '0;
        end else if (!bus.dense_en) begin
            vld_p1 <= 1'b0;
            vld_p2 <= 1'b0;
            acc    <= '0;
        end else begin
            vld_p1 <= bus.re;
            vld_p2 <= vld_p1;
            acc    <= (state == WRITE || state == IDLE) ? '0 : acc_sum;
        end
    end

endmodule

// File: tb/tb_dense_layer.sv
// Bench for dense_layer: two instances (FRAC=0 and FRAC=8) share stimulus and memory contents.
`timescale 1ns/1ps
module tb_dense_layer;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    dense_layer_if bus0 ();
    dense_layer_if bus8 ();

    dense_layer #(.FRAC(0)) dut0 (.clk(clk), .rst(rst), .bus(bus0));
    dense_layer #(.FRAC(8)) dut8 (.clk(clk), .rst(rst), .bus(bus8));

    logic        dense_en;
    logic [12:0] mp, mz;
    logic [13:0] mw;
    logic [9:0]  n;
    logic [6:0]  m;

    assign bus0.dense_en = dense_en;    assign bus8.dense_en = dense_en;
    assign bus0.memstartp = mp;         assign bus8.memstartp = mp;
    assign bus0.memstartzap = mz;       assign bus8.memstartzap = mz;
    assign bus0.memstartw = mw;         assign bus8.memstartw = mw;
    assign bus0.in_len = n;             assign bus8.in_len = n;
    assign bus0.out_len = m;            assign bus8.out_len = m;

    logic signed [10:0] pix [0:8191];
    logic signed [8:0]  wei [0:16383];

    // Memories with two-cycle read latency
    logic signed [10:0] p0_s1, p8_s1;
    logic signed [8:0]  w0_s1, w8_s1;
    always @(posedge clk) begin
        p0_s1   <= bus0.re   ? pix[bus0.read_addressp] : '0;
        w0_s1   <= bus0.re_w ? wei[bus0.read_addressw] : '0;
        p8_s1   <= bus8.re   ? pix[bus8.read_addressp] : '0;
        w8_s1   <= bus8.re_w ? wei[bus8.read_addressw] : '0;
        bus0.qp <= p0_s1;
        bus0.qw <= w0_s1;
        bus8.qp <= p8_s1;
        bus8.qw <= w8_s1;
    end

    int errors = 0;
    int checks = 0;
    logic signed [10:0] wr0_dp [0:127];
    logic signed [10:0] wr8_dp [0:127];
    int last_stop;

    task automatic chk(input string tag, input longint obs, input longint exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Reference: plain dot product over the memory arrays, then shift, clamp, optional ReLU
    function automatic longint expect_dp(input int o, input int frac);
        longint s = 0;
        longint r;
        for (int kk = 0; kk < int'(n); kk++)
            s += longint'(pix[(int'(mp) + kk) % 8192]) *
                 longint'(wei[(int'(mw) + o * int'(n) + kk) % 16384]);
        r = s >>> frac;
        if (r > 1023) r = 1023;
        if (r < -1024) r = -1024;
`ifdef DENSE_RELU_EN
        if (r < 0) r = 0;
`endif
        return r;
    endfunction

    task automatic fill_rand();
        for (int kk = 0; kk < int'(n); kk++) pix[(int'(mp) + kk) % 8192] = 11'($urandom);
        for (int i = 0; i < int'(m) * int'(n); i++) wei[(int'(mw) + i) % 16384] = 9'($urandom);
    endtask

    task automatic check_quiet(input string tag);
        chk({tag, " STOP"}, bus0.STOP, 0);
        chk({tag, " re"}, bus0.re, 0);
        chk({tag, " re_w"}, bus0.re_w, 0);
        chk({tag, " we"}, bus0.we, 0);
        chk({tag, " raddrp"}, bus0.read_addressp, 0);
        chk({tag, " raddrw"}, bus0.read_addressw, 0);
        chk({tag, " waddr"}, bus0.write_addressp, 0);
        chk({tag, " dp"}, bus0.dp, 0);
        chk({tag, " f8 enables"}, {bus8.STOP, bus8.re, bus8.re_w, bus8.we}, 0);
    endtask

    task automatic run_layer(input string name);
        int w0 = 0, w8 = 0, rd = 0, cyc;
        int lim = int'(m) * (int'(n) + 3) + 20;
        @(negedge clk);
        dense_en = 1'b1;
        for (cyc = 0; cyc < lim; cyc++) begin
            @(negedge clk);
            if (bus0.re_w) begin
                chk({name, " raddrw"}, bus0.read_addressw, (int'(mw) + rd) % 16384);
                chk({name, " raddrp"}, bus0.read_addressp, (int'(mp) + rd % int'(n)) % 8192);
                chk({name, " re with re_w"}, bus0.re, 1);
                rd++;
            end
            if (bus0.we) begin
                chk({name, " waddr"}, bus0.write_addressp, (int'(mz) + w0) % 8192);
                chk({name, " dp f0"}, bus0.dp, expect_dp(w0, 0));
                chk({name, " write cycle"}, cyc, w0 * (int'(n) + 3) + int'(n) + 3);
                wr0_dp[w0] = bus0.dp;
                w0++;
            end
            if (bus8.we) begin
                chk({name, " dp f8"}, bus8.dp, expect_dp(w8, 8));
                wr8_dp[w8] = bus8.dp;
                w8++;
            end
            if (bus0.STOP) break;
        end
        last_stop = cyc;
        chk({name, " STOP cycle"}, cyc, int'(m) * (int'(n) + 3) + 1);
        chk({name, " STOP f8"}, bus8.STOP, 1);
        chk({name, " writes f0"}, w0, int'(m));
        chk({name, " writes f8"}, w8, int'(m));
        chk({name, " reads"}, rd, int'(m) * int'(n));
    endtask

    task automatic end_layer(input string name);
        repeat (2) begin
            @(negedge clk);
            chk({name, " STOP held"}, bus0.STOP, 1);
        end
        dense_en = 1'b0;
        @(negedge clk);
        check_quiet({name, " release"});
    endtask

    initial begin
        rst = 1'b1; dense_en = 1'b0;
        mp = '0; mz = '0; mw = '0; n = 10'd1; m = 7'd1;
        repeat (2) @(negedge clk);
        check_quiet("reset");
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Single neuron, small values
        n = 10'd4; m = 7'd1; mp = 13'd10; mz = 13'd200; mw = 14'd50;
        for (int i = 0; i < 4; i++) begin pix[10 + i] = 11'(i + 1); wei[50 + i] = 9'sd1; end
        run_layer("single");
        chk("single dp const", wr0_dp[0], 10);
        chk("single stop const", last_stop, 8);
        end_layer("single");

        // Two weight rows, contiguous addressing
        n = 10'd3; m = 7'd2; mp = 13'd20; mz = 13'd300; mw = 14'd100;
        fill_rand();
        run_layer("multirow");
        end_layer("multirow");

        // Positive and negative saturation
        n = 10'd4; m = 7'd1; mp = 13'd40; mz = 13'd400; mw = 14'd200;
        for (int i = 0; i < 4; i++) begin pix[40 + i] = 11'sd1000; wei[200 + i] = 9'sd255; end
        run_layer("sat pos");
        chk("sat pos f0 const", wr0_dp[0], 1023);
        chk("sat pos f8 const", wr8_dp[0], 1023);
        end_layer("sat pos");
        for (int i = 0; i < 4; i++) pix[40 + i] = -11'sd1000;
        run_layer("sat neg");
`ifdef DENSE_RELU_EN
        chk("sat neg f0 const", wr0_dp[0], 0);
`else
        chk("sat neg f0 const", wr0_dp[0], -1024);
`endif
        end_layer("sat neg");

        // Scaling: acc = 768
        n = 10'd3; m = 7'd1; mp = 13'd60; mz = 13'd500; mw = 14'd300;
        for (int i = 0; i < 3; i++) begin pix[60 + i] = 11'sd256; wei[300 + i] = 9'sd1; end
        run_layer("scale");
        chk("scale f8 const", wr8_dp[0], 3);
        chk("scale f0 const", wr0_dp[0], 768);
        end_layer("scale");

        // Weight address wrap-around
        n = 10'd3; m = 7'd2; mp = 13'd80; mz = 13'd600; mw = 14'd16382;
        fill_rand();
        run_layer("wrap");
        end_layer("wrap");

        // Abort mid-issue of neuron 1 of 3, then clean restart
        n = 10'd5; m = 7'd3; mp = 13'd100; mz = 13'd700; mw = 14'd1000;
        fill_rand();
        @(negedge clk);
        dense_en = 1'b1;
        repeat (int'(n) + 7) @(negedge clk);
        chk("abort in issue", bus0.re, 1);
        dense_en = 1'b0;
        @(negedge clk);
        check_quiet("abort");
        run_layer("after abort");
        end_layer("after abort");

        // Asynchronous reset during DRAIN
        n = 10'd6; m = 7'd2; mp = 13'd130; mz = 13'd800; mw = 14'd2000;
        fill_rand();
        @(negedge clk);
        dense_en = 1'b1;
        repeat (int'(n) + 2) @(negedge clk);
        chk("drain re low", bus0.re, 0);
        #2 rst = 1'b1; dense_en = 1'b0;
        #1 check_quiet("async rst");
        @(negedge clk);
        rst = 1'b0;
        run_layer("after rst");
        end_layer("after rst");

        // Minimum size
        n = 10'd1; m = 7'd1; mp = 13'd150; mz = 13'd900; mw = 14'd3000;
        fill_rand();
        run_layer("min");
        chk("min stop const", last_stop, 5);
        end_layer("min");

        // Randomised layers
        for (int t = 0; t < 5; t++) begin
            n  = 10'($urandom_range(1, 24));
            m  = 7'($urandom_range(1, 5));
            mp = 13'($urandom_range(0, 4000));
            mz = 13'($urandom_range(5000, 8000));
            mw = 14'($urandom);
            fill_rand();
            run_layer($sformatf("rand%0d", t));
            end_layer($sformatf("rand%0d", t));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
